// File: rtl/ram_burst_read_streamer.sv
// Burst read streamer for a registered-output simple-dual-port RAM: issues one read per cycle
// under credit control, absorbs the fixed read latency and delivers words as a valid/ready stream.
module ram_burst_read_streamer #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   burst_len,
    output logic              busy,
    output logic              done,
    output logic              rd_req,
    output logic [ADDR_W-1:0] read_addr,
    output logic              out_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned INF_W = $clog2(RD_LAT + 1);
    localparam int unsigned SUM_W = $clog2(FIFO_DEPTH + RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state, state_next;
    logic [LEN_W-1:0]    len_q, len_next;
    logic [LEN_W-1:0]    issue_left, issue_left_next;
    logic [LEN_W-1:0]    delivered, delivered_next;
    logic [ADDR_W-1:0]   read_addr_next;
    logic                rd_req_next;
    logic [RD_LAT-1:0]   pipe, pipe_next;
    logic [INF_W-1:0]    inflight_next;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_ptr_inc;
    logic [CNT_W-1:0]    count, count_next;
    logic [DATA_W-1:0]   m_data_next;
    logic                m_last_next;
    logic                accept, push, pop;

    assign accept     = (state == S_IDLE) && start;
    assign push       = pipe[RD_LAT-1];
    assign pop        = m_valid && m_ready;
    assign rd_ptr_inc = PTR_W'(rd_ptr + PTR_W'(1));

    // Next-state, credit and stream-head computation
    always_comb begin
        state_next      = state;
        len_next        = len_q;
        issue_left_next = issue_left;
        delivered_next  = LEN_W'(delivered + LEN_W'(pop));
        read_addr_next  = read_addr;
        pipe_next       = RD_LAT'({pipe, rd_req});
        count_next      = CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
        inflight_next   = '0;
        m_data_next     = m_data;
        m_last_next     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    len_next        = burst_len;
                    issue_left_next = burst_len;
                    delivered_next  = '0;
                    read_addr_next  = base_addr;
                    state_next      = (burst_len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rd_req) begin
                    issue_left_next = LEN_W'(issue_left - LEN_W'(1));
                    read_addr_next  = ADDR_W'(read_addr + ADDR_W'(1));
                    if (issue_left == LEN_W'(1)) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && m_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight_next = INF_W'(inflight_next + INF_W'(pipe_next[i]));
        end

        // A read may only be issued if its word is guaranteed a FIFO slot
        rd_req_next = (state_next == S_ISSUE) &&
                      ((SUM_W'(count_next) + SUM_W'(inflight_next)) < SUM_W'(FIFO_DEPTH));

        if (count_next != '0) begin
            if (pop) begin
                m_data_next = (count == CNT_W'(1)) ? rd_data : mem[rd_ptr_inc];
            end else if (count == '0) begin
                m_data_next = rd_data;
            end else begin
                m_data_next = mem[rd_ptr];
            end
            m_last_next = (delivered_next == LEN_W'(len_next - LEN_W'(1)));
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            len_q      <= '0;
            issue_left <= '0;
            delivered  <= '0;
            read_addr  <= '0;
            rd_req     <= 1'b0;
            pipe       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_en     <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            state      <= state_next;
            len_q      <= len_next;
            issue_left <= issue_left_next;
            delivered  <= delivered_next;
            read_addr  <= read_addr_next;
            rd_req     <= rd_req_next;
            pipe       <= pipe_next;
            count      <= count_next;
            busy       <= (state_next != S_IDLE);
            done       <= (state_next == S_DONE);
            out_en     <= (inflight_next != '0) || rd_req_next;
            m_valid    <= (count_next != '0);
            m_data     <= m_data_next;
            m_last     <= m_last_next;
            if (push) begin
                mem[wr_ptr] <= rd_data;
                wr_ptr      <= PTR_W'(wr_ptr + PTR_W'(1));
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_read_streamer.sv
// Directed bench for ram_burst_read_streamer with a registered-read RAM model (RAM[i] = i*3).
module tb_ram_burst_read_streamer;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   burst_len;
    logic              busy, done, rd_req, out_en, m_valid, m_ready, m_last;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] rd_data, m_data;

    ram_burst_read_streamer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .burst_len(burst_len), .busy(busy), .done(done), .rd_req(rd_req),
        .read_addr(read_addr), .out_en(out_en), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // RAM: read register then output register held by out_en
    logic [DATA_W-1:0] ram [512];
    logic [DATA_W-1:0] ram_q;
    initial begin
        for (int i = 0; i < 512; i++) ram[i] = DATA_W'(i * 3);
        ram_q   = '0;
        rd_data = '0;
    end
    always @(posedge clk) begin
        ram_q <= ram[read_addr];
        if (out_en) rd_data <= ram_q;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stream monitor sampled mid-cycle
    logic        mon_clr = 1'b0;
    logic [31:0] addr_q[$];
    logic [31:0] data_q[$];
    int issued, popped, out_now, max_out, done_cnt, done_cyc, first_issue;
    int busy_cnt, mv_cnt, last_cnt, last_idx;

    always @(negedge clk) begin
        if (mon_clr) begin
            addr_q.delete(); data_q.delete();
            issued = 0; popped = 0; out_now = 0; max_out = 0; done_cnt = 0; done_cyc = -1;
            first_issue = -1; busy_cnt = 0; mv_cnt = 0; last_cnt = 0; last_idx = 0;
        end else if (reset) begin
            if (rd_req) begin
                addr_q.push_back(32'(read_addr));
                issued++;
                if (first_issue < 0) first_issue = cyc;
            end
            out_now = issued - popped;
            if (out_now > max_out) max_out = out_now;
            if (m_valid) mv_cnt++;
            if (m_valid && m_ready) begin
                data_q.push_back(m_data);
                popped++;
                if (m_last) begin
                    last_cnt++;
                    last_idx = data_q.size();
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
        start = 1'b1; base_addr = b; burst_len = l;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && done_cnt == 0; i++) step();
        repeat (4) step();
        check("done_count", done_cnt, 1);
    endtask

    task automatic check_stream(input string tag, input int b, input int n);
        logic [31:0] a_exp, a_got, d_got;
        check({tag, "_naddr"}, addr_q.size(), n);
        check({tag, "_ndata"}, data_q.size(), n);
        for (int i = 0; i < n; i++) begin
            a_exp = 32'((b + i) % 512);
            a_got = (i < addr_q.size()) ? addr_q[i] : 32'hFFFF_FFFF;
            d_got = (i < data_q.size()) ? data_q[i] : 32'hFFFF_FFFF;
            check({tag, "_addr"}, a_got, a_exp);
            check({tag, "_data"}, d_got, a_exp * 3);
        end
        check({tag, "_last_cnt"}, last_cnt, 1);
        check({tag, "_last_idx"}, last_idx, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; burst_len = '0; m_ready = 1'b1;
        repeat (3) step();
        check("rst_ctrl", {busy, done, rd_req, out_en, m_valid, m_last}, 0);
        check("rst_addr", read_addr, 0);
        check("rst_data", m_data, 0);
        reset = 1'b1;
        step();

        // 1: basic burst, full throughput and latency
        clear_mon();
        pulse_start(9'h010, 10'd4);
        wait_done();
        check_stream("t1", 'h010, 4);
        check("t1_done_lat", done_cyc - first_issue, 4 + 3);
        check("t1_busy_cycles", busy_cnt, 8);

        // 2: address wrap at top of RAM
        clear_mon();
        pulse_start(9'h1FE, 10'd4);
        wait_done();
        check_stream("t2", 'h1FE, 4);

        // 3: consumer stall caps outstanding reads at FIFO depth
        clear_mon();
        pulse_start(9'h080, 10'd16);
        repeat (3) step();
        m_ready = 1'b0;
        repeat (8) step();
        check("t3_stall_outstanding", out_now, 4);
        check("t3_stall_rd_req", rd_req, 0);
        m_ready = 1'b1;
        wait_done();
        check_stream("t3", 'h080, 16);
        check("t3_max_outstanding", max_out, 4);

        // 4: empty burst
        clear_mon();
        pulse_start(9'h055, 10'd0);
        wait_done();
        check("t4_rd_reqs", addr_q.size(), 0);
        check("t4_busy_cycles", busy_cnt, 1);
        check("t4_m_valid_cycles", mv_cnt, 0);

        // 5: reset mid-burst, then a clean burst
        clear_mon();
        pulse_start(9'h000, 10'd32);
        for (int i = 0; i < 200 && data_q.size() < 4; i++) step();
        #2 reset = 1'b0;
        #1;
        check("t5_rst_ctrl", {busy, done, rd_req, out_en, m_valid, m_last}, 0);
        check("t5_rst_addr", read_addr, 0);
        check("t5_rst_data", m_data, 0);
        check("t5_no_done", done_cnt, 0);
        repeat (2) step();
        reset = 1'b1;
        clear_mon();
        pulse_start(9'h000, 10'd2);
        wait_done();
        check_stream("t5", 0, 2);

        // 6: start while busy is ignored
        clear_mon();
        pulse_start(9'h040, 10'd8);
        repeat (2) step();
        pulse_start(9'h100, 10'd3);
        wait_done();
        repeat (10) step();
        check_stream("t6", 'h040, 8);
        check("t6_single_done", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
